// File: rtl/subcarrier_sched.sv
// -----------------------------------------------------------------------------
// subcarrier_sched
//
// Collects 48 mapped data-subcarrier samples per OFDM symbol and emits the
// 64 IFFT bins of that symbol in natural bin order (0..63). Null bins
// (DC and the guard band 27..37) carry zero, and the four pilot bins carry
// +/-PILOT_AMP scaled by the symbol's pilot polarity p.
//
// A packet ends on the symbol whose samples carry in_last. A short final
// symbol (in_last before the 48th sample) has its missing slots read as zero.
//
// Build option:
//   PILOT_POLARITY_EN  - when defined, p follows a 7-bit x^7+x^4+1 LFSR
//                        (seed 7'h7F, one step per emitted symbol, reseeded
//                        at every packet end). When undefined p = +1.
// -----------------------------------------------------------------------------
module subcarrier_sched #(
    parameter int                  W         = 16,
    parameter logic signed [W-1:0] PILOT_AMP = 16'sd11585
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_i,
    input  logic signed [W-1:0] in_q,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_i,
    output logic signed [W-1:0] out_q,
    output logic [5:0]          out_idx,
    output logic                out_sof,
    output logic                out_eof,
    output logic                short_sym
);

    // Negated pilot; PILOT_AMP is never the most-negative value, so this is exact.
    localparam logic signed [W-1:0] PILOT_NEG = -PILOT_AMP;
    localparam logic [5:0]          LAST_SLOT = 6'd47;
    localparam logic [5:0]          LAST_BIN  = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Bin-to-slot mapping. Data slots run over k = -26..26 ascending, skipping
    // k = 0, +/-7 and +/-21; negative k live at bin k+64. Returns
    // {is_data, slot}.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] bin_slot(input logic [5:0] b);
        logic [6:0] r;
        r = 7'd0;
        if ((b >= 6'd1) && (b <= 6'd6)) begin
            r = {1'b1, b + 6'd23};
        end else if ((b >= 6'd8) && (b <= 6'd20)) begin
            r = {1'b1, b + 6'd22};
        end else if ((b >= 6'd22) && (b <= 6'd26)) begin
            r = {1'b1, b + 6'd21};
        end else if ((b >= 6'd38) && (b <= 6'd42)) begin
            r = {1'b1, b - 6'd38};
        end else if ((b >= 6'd44) && (b <= 6'd56)) begin
            r = {1'b1, b - 6'd39};
        end else if ((b >= 6'd58) && (b <= 6'd63)) begin
            r = {1'b1, b - 6'd40};
        end else begin
            r = 7'd0;
        end
        return r;
    endfunction

    // Pilot classification: {is_pilot, base_negated}. Bin 21 (k=+21) carries
    // the inverted pilot; bins 43, 57 and 7 carry the non-inverted pilot.
    function automatic logic [1:0] pilot_kind(input logic [5:0] b);
        logic [1:0] r;
        case (b)
            6'd43:   r = 2'b10;
            6'd57:   r = 2'b10;
            6'd7:    r = 2'b10;
            6'd21:   r = 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic                accept_s;     // sample taken this cycle
    logic                fin_s;        // sample taken completes the symbol
    logic                adv_s;        // bin accepted, more bins follow
    logic                done_s;       // bin 63 accepted

    logic [5:0]          dcnt_r;
    logic [5:0]          fill_len_r;   // number of slots written this symbol
    logic                last_r;       // current symbol closes the packet
    logic                short_sym_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [5:0]          out_idx_r;
    logic signed [W-1:0] out_i_r;
    logic signed [W-1:0] out_q_r;
    logic                out_sof_r;
    logic                out_eof_r;

    logic signed [W-1:0] sbuf_i_r [0:47];
    logic signed [W-1:0] sbuf_q_r [0:47];

    logic [5:0]          nxt_idx_s;
    logic [6:0]          slot_info_s;
    logic [1:0]          pil_info_s;
    logic signed [W-1:0] nxt_i_s;
    logic signed [W-1:0] nxt_q_s;
    logic                p_neg_s;      // pilot polarity of the symbol: 1 -> p = -1

`ifdef PILOT_POLARITY_EN
    logic [6:0] lfsr_r;

    // The next sequence bit (x^7 + x^4 feedback) is the polarity of the current symbol.
    assign p_neg_s = lfsr_r[6] ^ lfsr_r[3];

    // Step the polarity LFSR once per emitted symbol; reseed at packet end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 7'h7F;
        end else if (done_s) begin
            if (last_r) begin
                lfsr_r <= 7'h7F;
            end else begin
                lfsr_r <= {lfsr_r[5:0], p_neg_s};
            end
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    assign p_neg_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the handshake strobes that drive the datapath.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        fin_s       = 1'b0;
        adv_s       = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_FILL: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    if (in_last || (dcnt_r == LAST_SLOT)) begin
                        fin_s       = 1'b1;
                        state_nxt_s = ST_EMIT;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_EMIT: begin
                if (out_valid_r && out_ready) begin
                    if (out_idx_r == LAST_BIN) begin
                        done_s      = 1'b1;
                        state_nxt_s = last_r ? ST_IDLE : ST_FILL;
                    end else begin
                        adv_s       = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered handshake flags, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s != ST_EMIT);
            out_valid_r <= (state_nxt_s == ST_EMIT);
        end
    end

    // Sample buffer; contents need no reset because fill_len_r masks stale slots.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            sbuf_i_r[dcnt_r] <= in_i;
            sbuf_q_r[dcnt_r] <= in_q;
        end else begin
            sbuf_i_r[dcnt_r] <= sbuf_i_r[dcnt_r];
            sbuf_q_r[dcnt_r] <= sbuf_q_r[dcnt_r];
        end
    end

    // Fill-side bookkeeping: slot counter, filled length, last flag, short pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_r      <= 6'd0;
            fill_len_r  <= 6'd0;
            last_r      <= 1'b0;
            short_sym_r <= 1'b0;
        end else begin
            short_sym_r <= accept_s && in_last && (dcnt_r != LAST_SLOT);
            if (fin_s) begin
                dcnt_r     <= 6'd0;
                fill_len_r <= dcnt_r + 6'd1;
                last_r     <= in_last;
            end else if (accept_s) begin
                dcnt_r     <= dcnt_r + 6'd1;
            end else if (done_s) begin
                dcnt_r     <= 6'd0;
                last_r     <= 1'b0;
            end else begin
                dcnt_r     <= dcnt_r;
            end
        end
    end

    // Value of the bin that follows the one currently presented.
    always_comb begin
        nxt_idx_s   = out_idx_r + 6'd1;
        slot_info_s = bin_slot(nxt_idx_s);
        pil_info_s  = pilot_kind(nxt_idx_s);
        nxt_i_s     = {W{1'b0}};
        nxt_q_s     = {W{1'b0}};
        if (slot_info_s[6]) begin
            if (slot_info_s[5:0] < fill_len_r) begin
                nxt_i_s = sbuf_i_r[slot_info_s[5:0]];
                nxt_q_s = sbuf_q_r[slot_info_s[5:0]];
            end else begin
                nxt_i_s = {W{1'b0}};
                nxt_q_s = {W{1'b0}};
            end
        end else if (pil_info_s[1]) begin
            nxt_i_s = (pil_info_s[0] ^ p_neg_s) ? PILOT_NEG : PILOT_AMP;
            nxt_q_s = {W{1'b0}};
        end else begin
            nxt_i_s = {W{1'b0}};
            nxt_q_s = {W{1'b0}};
        end
    end

    // Emit-side output registers: load bin 0 on symbol completion, then step
    // one bin per accepted handshake, holding everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_r <= 6'd0;
            out_i_r   <= {W{1'b0}};
            out_q_r   <= {W{1'b0}};
            out_sof_r <= 1'b0;
            out_eof_r <= 1'b0;
        end else if (fin_s) begin
            out_idx_r <= 6'd0;
            out_i_r   <= {W{1'b0}};
            out_q_r   <= {W{1'b0}};
            out_sof_r <= 1'b1;
            out_eof_r <= 1'b0;
        end else if (adv_s) begin
            out_idx_r <= nxt_idx_s;
            out_i_r   <= nxt_i_s;
            out_q_r   <= nxt_q_s;
            out_sof_r <= 1'b0;
            out_eof_r <= last_r && (nxt_idx_s == LAST_BIN);
        end else if (done_s) begin
            out_idx_r <= 6'd0;
            out_i_r   <= {W{1'b0}};
            out_q_r   <= {W{1'b0}};
            out_sof_r <= 1'b0;
            out_eof_r <= 1'b0;
        end else begin
            out_idx_r <= out_idx_r;
            out_i_r   <= out_i_r;
            out_q_r   <= out_q_r;
            out_sof_r <= out_sof_r;
            out_eof_r <= out_eof_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_i     = out_i_r;
    assign out_q     = out_q_r;
    assign out_sof   = out_sof_r;
    assign out_eof   = out_eof_r;
    assign short_sym = short_sym_r;

endmodule

// File: tb/tb_subcarrier_sched.sv
// -----------------------------------------------------------------------------
// tb_subcarrier_sched
//
// Directed stimulus for subcarrier_sched. A behavioural model builds the 64
// expected bins of every symbol from the subcarrier plan (k = -26..26, pilots,
// nulls) and queues them; one compare process checks every presented bin.
// Literal checks pin a few model results (slot/bin placement, pilot values,
// polarity sequence start). Honours PILOT_POLARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_subcarrier_sched;

    localparam int W   = 16;
    localparam int AMP = 11585;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_i;
    logic signed [W-1:0] in_q;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_i;
    logic signed [W-1:0] out_q;
    logic [5:0]          out_idx;
    logic                out_sof;
    logic                out_eof;
    logic                short_sym;

    subcarrier_sched #(.W(W), .PILOT_AMP(16'sd11585)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_q      (in_q),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .short_sym (short_sym)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int exp_i_q[$];
    int exp_q_q[$];
    bit exp_eof_q[$];
    int exp_idx = 0;
    int cap_i [0:63];
    int short_cnt = 0;
    int eof_cnt = 0;
    int rmode = 0;
    bit lb [0:199];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Pilot polarity of symbol m of a packet: +1 or -1.
    function automatic int pol(input int m);
`ifdef PILOT_POLARITY_EN
        return lb[m + 7] ? -1 : 1;
`else
        return (m >= 0) ? 1 : 1;
`endif
    endfunction

    // Compare process: every presented bin against the head of the model queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_i_q.delete();
                exp_q_q.delete();
                exp_eof_q.delete();
                exp_idx = 0;
            end else begin
                checks++;
                if (in_ready !== !out_valid) begin
                    errors++;
                    $display("FAIL ready_vs_valid: in_ready=%0b out_valid=%0b", in_ready, out_valid);
                end
                if (out_valid) begin
                    checks++;
                    if (exp_i_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_bin: idx=%0d i=%0d with no bin expected", out_idx, out_i);
                    end else begin
                        if ((int'(out_idx) != exp_idx) || (int'(out_i) != exp_i_q[0]) ||
                            (int'(out_q) != exp_q_q[0]) || (out_sof != (exp_idx == 0)) ||
                            (out_eof != exp_eof_q[0])) begin
                            errors++;
                            $display("FAIL bin: got idx=%0d i=%0d q=%0d sof=%0b eof=%0b expected idx=%0d i=%0d q=%0d sof=%0b eof=%0b",
                                     out_idx, out_i, out_q, out_sof, out_eof,
                                     exp_idx, exp_i_q[0], exp_q_q[0], (exp_idx == 0), exp_eof_q[0]);
                        end
                        if (out_ready) begin
                            cap_i[exp_idx] = int'(out_i);
                            void'(exp_i_q.pop_front());
                            void'(exp_q_q.pop_front());
                            void'(exp_eof_q.pop_front());
                            exp_idx = (exp_idx + 1) % 64;
                        end
                    end
                end
            end
        end
    end

    // Pulse counters for short_sym and out_eof (eof counted once per accepted bin).
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && short_sym) short_cnt++;
            if (rst_n && out_valid && out_ready && out_eof) eof_cnt++;
        end
    end

    // out_ready driver: mode 0 always ready, mode 1 repeating 1,0,0,1.
    initial begin
        int cyc;
        bit [3:0] pat;
        cyc = 0;
        pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 1) begin
                out_ready = pat[3 - (cyc % 4)];
                cyc++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Present one symbol (nsamp samples) and queue its expected bins.
    task automatic send_sym(input int nsamp, input bit is_last, input int pat, input int sym_no);
        logic signed [15:0] si [0:47];
        logic signed [15:0] sq [0:47];
        int ei [0:63];
        int eq [0:63];
        int slot, b, p, guard;
        bit acc;
        for (int i = 0; i < 48; i++) begin
            si[i] = 16'sd0;
            sq[i] = 16'sd0;
            if (i < nsamp) begin
                if (pat == 0) begin
                    si[i] = 16'(i);
                end else begin
                    si[i] = 16'($urandom);
                    sq[i] = 16'($urandom);
                end
            end
        end
        for (int i = 0; i < 64; i++) begin
            ei[i] = 0;
            eq[i] = 0;
        end
        slot = 0;
        for (int k = -26; k <= 26; k++) begin
            if (k == 0 || k == 7 || k == -7 || k == 21 || k == -21) continue;
            b = (k < 0) ? k + 64 : k;
            if (slot < nsamp) begin
                ei[b] = int'(si[slot]);
                eq[b] = int'(sq[slot]);
            end
            slot++;
        end
        p = pol(sym_no);
        ei[43] = p * AMP;
        ei[57] = p * AMP;
        ei[7]  = p * AMP;
        ei[21] = -p * AMP;
        for (int s = 0; s < nsamp; s++) begin
            if (s == nsamp - 1) begin
                for (int i = 0; i < 64; i++) begin
                    exp_i_q.push_back(ei[i]);
                    exp_q_q.push_back(eq[i]);
                    exp_eof_q.push_back(is_last && (i == 63));
                end
            end
            in_valid = 1'b1;
            in_i     = si[s];
            in_q     = sq[s];
            in_last  = is_last && (s == nsamp - 1);
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 2000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: sample %0d not accepted, got in_ready=0 expected 1", s);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait until every queued bin has been emitted and the block is idle.
    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (exp_i_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: got %0d bins pending expected 0", name, exp_i_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int nz;
        bit [7:0] seq8;
        // Polarity sequence model: all-ones history, b[n] = b[n-7] ^ b[n-4].
        for (int i = 0; i < 7; i++) lb[i] = 1'b1;
        for (int n = 7; n < 200; n++) lb[n] = lb[n-7] ^ lb[n-4];
        for (int m = 0; m < 8; m++) seq8[7-m] = lb[m+7];
        chk("polarity_seq_start", int'(seq8), 8'b0000_1110);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_i     = 16'sd0;
        in_q     = 16'sd0;
        in_last  = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx",   int'(out_idx),   0);
        chk("rst_out_i",     int'(out_i),     0);
        chk("rst_flags",     int'({out_sof, out_eof, short_sym}), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready",  int'(in_ready),  1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // Full symbol, I = slot index, last on slot 47.
        send_sym(48, 1'b1, 0, 0);
        wait_idle("t1");
        chk("t1_bin38", cap_i[38], 0);
        chk("t1_bin39", cap_i[39], 1);
        chk("t1_bin42", cap_i[42], 4);
        chk("t1_bin1",  cap_i[1],  24);
        chk("t1_bin26", cap_i[26], 47);
        chk("t1_bin63", cap_i[63], 23);
        nz = 0;
        for (int b = 27; b <= 37; b++) if (cap_i[b] != 0) nz++;
        if (cap_i[0] != 0) nz++;
        chk("t1_null_bins", nz, 0);
        chk("t1_pilot43", cap_i[43], AMP);
        chk("t1_pilot57", cap_i[57], AMP);
        chk("t1_pilot7",  cap_i[7],  AMP);
        chk("t1_pilot21", cap_i[21], -AMP);
        chk("t1_eof_count", eof_cnt, 1);
        chk("t1_short_count", short_cnt, 0);

        // Two-symbol packet with random data.
        send_sym(48, 1'b0, 1, 0);
        send_sym(48, 1'b1, 1, 1);
        wait_idle("t2");
        chk("t2_eof_count", eof_cnt, 2);

        // Short symbol: in_last on sample 10.
        send_sym(11, 1'b1, 0, 0);
        wait_idle("t3");
        chk("t3_short_count", short_cnt, 1);
        chk("t3_slot10_bin49", cap_i[49], 10);
        chk("t3_slot11_bin50", cap_i[50], 0);
        chk("t3_slot24_bin1",  cap_i[1],  0);
        send_sym(48, 1'b1, 0, 0);
        wait_idle("t3b");
        chk("t3b_short_count", short_cnt, 1);
        chk("t3b_bin1", cap_i[1], 24);

        // Backpressure 1,0,0,1 during emission.
        rmode = 1;
        send_sym(48, 1'b0, 1, 0);
        send_sym(48, 1'b1, 1, 1);
        wait_idle("t4");
        rmode = 0;
        @(posedge clk);
        #1;

        // Reset in the middle of emission at out_idx 30.
        send_sym(48, 1'b1, 1, 0);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                @(negedge clk);
                if (out_valid && out_idx == 6'd30) hit = 1'b1;
            end
            chk("t5_reach_idx30", int'(hit), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_out_idx",   int'(out_idx),   0);
        chk("t5_rst_out_i",     int'(out_i),     0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send_sym(48, 1'b1, 0, 0);
        wait_idle("t5");
        chk("t5_slot0_bin38", cap_i[38], 0);
        chk("t5_slot1_bin39", cap_i[39], 1);

        // 130-symbol packet; pilot polarity wraps after 127 symbols.
        for (int s = 0; s < 130; s++) send_sym(48, (s == 129), 1, s);
        wait_idle("t6");
        chk("t6_short_count", short_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
